wave_display_mc: RTL and testbench
==================================

# wave_display_mc

Multi-channel, parametrised oscilloscope renderer for the VGA/HDMI pixel pipeline. Consumes the raster position (x, y, valid) and draws up to NUM_CH sample traces from a shared-address sample RAM into a fixed window, one colour per channel. Each pixel is lit when it lies between consecutive samples. A 2-stage pipeline compensates the RAM's 1-cycle read latency. The displayed RAM half and channel enables are latched at frame start so traces never tear mid-frame.

## Interface
- NUM_CH, 2, number of traces (1..4)
- SAMPLE_W, 8, bits per sample
- IDX_W, 8, log2 samples per trace; RAM holds two halves
- X_SHIFT, 1, pixels per sample = 2^X_SHIFT
- Y_SHIFT, 1, rows per sample step = 2^Y_SHIFT
- X_START, 384, first window column (must be > 0)
- Y_START, 256, first window row
- CH_COLORS, {24'hFF00FF, 24'h00FF00}, packed NUM_CH*24 {r,g,b}; channel c at [c*24 +: 24]

- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- x  in  11  raster column
- y  in  10  raster row
- valid  in  1  x/y denote a visible pixel
- read_index  in  1  RAM half currently safe to display
- ch_en  in  NUM_CH  per-channel enable
- freeze  in  1  1 = hold latched index/enables
- read_value  in  NUM_CH*SAMPLE_W  RAM data, channel c at [c*SAMPLE_W +: SAMPLE_W], 1 cycle after read_address
- read_address  out  IDX_W+1  {shown_index, sample_no}, combinational
- valid_pixel  out  1  pixel lit by some channel
- r, g, b  out  8 each  pixel colour; 0 when valid_pixel = 0

## Operation
- Window: in_win = valid & X_START ≤ x < X_START + (2^IDX_W << X_SHIFT) & Y_START ≤ y < Y_START + (2^SAMPLE_W << Y_SHIFT). Defaults: x 384..895, y 256..767.
- sample_no = (x − X_START) >> X_SHIFT, truncated to IDX_W bits; new_sample = in_win & low X_SHIFT bits of (x − X_START) are 0; first = (x == X_START).
- Frame latch: on valid & x==0 & y==0 & !freeze, set shown_index <= read_index and en_q <= ch_en.
- Stage 1 (registered x-path flags, y row, in_win, new_sample, first). Per channel, when new_sample: cur <= read_value_c, prev <= first ? read_value_c : cur. Otherwise hold.
- Compare uses updated values (cur_s/prev_s, i.e. bypassed on new_sample). Target row t = (2^SAMPLE_W − 1) − s. Row index rr = (y − Y_START) >> Y_SHIFT. Channel lit = en_q[c] & in_win & min(t_prev,t_cur) ≤ rr ≤ max(t_prev,t_cur).
- Priority: lowest-index lit channel supplies the colour.
- Stage 2 register: valid_pixel = any lit; {r,g,b} = colour or 0.
- All comparisons are unsigned at width SAMPLE_W+1, with no wrap.

## Timing
- Latency: x/y/valid at edge n → valid_pixel, r, g, b at edge n+2. Throughput is 1 pixel/clk with no stalls.
- read_address is combinational from x and shown_index. read_value presented at cycle n+1 must correspond to it.
- Reset values: valid_pixel=0, r=g=b=0, shown_index=0, en_q=all ones, cur=prev=0, pipeline valid flags 0. read_address follows x with index 0.
- Reset asserted mid-line: outputs go to 0 immediately (asynchronous). After release, the first trace segment of each channel starts at the next first pixel (prev=cur).
- read_index or ch_en changing mid-frame has no effect until the next x=0,y=0. When freeze is held, the latched values never change.
- valid=0 inside the window: no sample update and no pixel lit.

## Structure
- Shared package wave_display_pkg: default widths (SAMPLE_W, IDX_W, X_W=11, Y_W=10), window defaults, and named 24-bit colour constants.
- Sub-module wave_channel_cmp (prev/cur registers, bypass, min/max range compare) is instantiated NUM_CH times via generate. The top level holds the frame latch, window decode, priority encoder, and output register.

## Test plan
- ch0 constant 128, ch1 disabled → valid_pixel=1 and rgb=00FF00 only at y=510,511 for x=384..895, 2 cycles after presentation; 0 elsewhere.
- ch0 ramp sample k=k → at x=384 only y=766,767 are lit (prev=cur=0). At x=384+2k (k≥1), rows 255−k..256−k are lit, i.e. y=766−2k..769−2k.
- Both channels constant 64 → all lit pixels show ch0 colour 00FF00. Disabling ch0 at the next frame start → FF00FF.
- Toggle read_index at x=500,y=300 → read_address MSB changes only after the next x=0,y=0. Repeat with freeze=1 → MSB never changes.
- Assert reset at x=600 mid-row → r,g,b,valid_pixel=0 in the same cycle. After release, the next row's first pixel uses prev=cur.
- Pixels at x=383, x=896, y=255, y=768, and in-window pixels with valid=0 → valid_pixel=0, rgb=0.

Source files
------------

// File: rtl/wave_display_pkg.sv
// wave_display_pkg: shared widths, window defaults, colours and pipeline types
// Used by wave_display_mc (top) and wave_channel_cmp (per-channel compare).
package wave_display_pkg;
    localparam int DEF_SAMPLE_W = 8;
    localparam int DEF_IDX_W = 8;
    localparam int X_W = 11;
    localparam int Y_W = 10;
    localparam int DEF_X_SHIFT = 1;
    localparam int DEF_Y_SHIFT = 1;
    localparam int DEF_X_START = 384;
    localparam int DEF_Y_START = 256;
    localparam logic [23:0] COLOR_GREEN = 24'h00FF00;
    localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
    typedef struct packed {
        logic in_win;
        logic new_sample;
        logic first;
    } pix_flags_t;
endpackage

// File: rtl/wave_channel_cmp.sv
// wave_channel_cmp: one trace's prev/cur sample registers and row-range compare
// Ports: clk, reset (async, active-high); new_sample/first/in_win/row are the
// stage-1 pixel attributes; en is the frame-latched channel enable; value is
// the RAM sample for this channel; lit = pixel lies between prev and cur.
module wave_channel_cmp
    import wave_display_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample,
    input  logic                first,
    input  logic                in_win,
    input  logic                en,
    input  logic [SAMPLE_W:0]   row,
    input  logic [SAMPLE_W-1:0] value,
    output logic                lit
);
    localparam logic [SAMPLE_W:0] TOP_ROW = {1'b0, {SAMPLE_W{1'b1}}};

    logic [SAMPLE_W-1:0] cur, prev, cur_s, prev_s;
    logic [SAMPLE_W:0] t_cur, t_prev, lo, hi;

    // Bypass so the pixel that loads a new sample is drawn with it; the first
    // sample of a row has no predecessor, so its segment collapses to a point.
    assign cur_s = new_sample ? value : cur;
    assign prev_s = new_sample ? (first ? value : cur) : prev;
    assign t_cur = TOP_ROW - {1'b0, cur_s};
    assign t_prev = TOP_ROW - {1'b0, prev_s};
    assign lo = (t_prev < t_cur) ? t_prev : t_cur;
    assign hi = (t_prev < t_cur) ? t_cur : t_prev;
    assign lit = en && in_win && row >= lo && row <= hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= '0;
            prev <= '0;
        end else begin
            cur <= cur_s;
            prev <= prev_s;
        end
    end
endmodule

// File: rtl/wave_display_mc.sv
// wave_display_mc: multi-channel oscilloscope trace renderer for the pixel pipeline
// Ports: clk, reset (async, active-high); x/y/valid raster position;
// read_index = RAM half safe to show; ch_en per-channel enables; freeze holds
// the frame-latched index/enables; read_value = RAM data one cycle after
// read_address; read_address = {shown_index, sample_no} (combinational);
// valid_pixel/r/g/b = pixel output two cycles after x/y/valid.
module wave_display_mc
    import wave_display_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int IDX_W = DEF_IDX_W,
    parameter int X_SHIFT = DEF_X_SHIFT,
    parameter int Y_SHIFT = DEF_Y_SHIFT,
    parameter int X_START = DEF_X_START,
    parameter int Y_START = DEF_Y_START,
    parameter logic [NUM_CH*24-1:0] CH_COLORS = {COLOR_MAGENTA, COLOR_GREEN}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [X_W-1:0]             x,
    input  logic [Y_W-1:0]             y,
    input  logic                       valid,
    input  logic                       read_index,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic                       freeze,
    input  logic [NUM_CH*SAMPLE_W-1:0] read_value,
    output logic [IDX_W:0]             read_address,
    output logic                       valid_pixel,
    output logic [7:0]                 r,
    output logic [7:0]                 g,
    output logic [7:0]                 b
);
    localparam int CW = SAMPLE_W + 1;
    localparam int X_END = X_START + ((1 << IDX_W) << X_SHIFT);
    localparam int Y_END = Y_START + ((1 << SAMPLE_W) << Y_SHIFT);

    logic shown_index;
    logic [NUM_CH-1:0] en_q;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    pix_flags_t s0, s1;
    logic [CW-1:0] row0, row1;
    logic [NUM_CH-1:0] lit;
    logic [23:0] color;

    assign dx = x - X_W'(X_START);
    assign dy = y - Y_W'(Y_START);
    assign s0.in_win = valid
        && 32'(x) >= 32'(X_START) && 32'(x) < 32'(X_END)
        && 32'(y) >= 32'(Y_START) && 32'(y) < 32'(Y_END);
    assign s0.new_sample = s0.in_win && (dx & X_W'((1 << X_SHIFT) - 1)) == '0;
    assign s0.first = x == X_W'(X_START);
    assign row0 = CW'(dy >> Y_SHIFT);
    assign read_address = {shown_index, IDX_W'(dx >> X_SHIFT)};

    // Index and enables only move at frame start so a frame never mixes halves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shown_index <= 1'b0;
            en_q <= '1;
            s1 <= '0;
            row1 <= '0;
        end else begin
            if (valid && x == '0 && y == '0 && !freeze) begin
                shown_index <= read_index;
                en_q <= ch_en;
            end
            s1 <= s0;
            row1 <= row0;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wave_channel_cmp #(.SAMPLE_W(SAMPLE_W)) u_cmp (
            .clk(clk),
            .reset(reset),
            .new_sample(s1.new_sample),
            .first(s1.first),
            .in_win(s1.in_win),
            .en(en_q[c]),
            .row(row1),
            .value(read_value[c*SAMPLE_W +: SAMPLE_W]),
            .lit(lit[c])
        );
    end

    // Scan from the top so the lowest-index lit channel wins.
    always_comb begin
        color = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (lit[i]) color = CH_COLORS[i*24 +: 24];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pixel <= 1'b0;
            {r, g, b} <= '0;
        end else begin
            valid_pixel <= |lit;
            {r, g, b} <= color;
        end
    end
endmodule

// File: tb/tb_wave_display_mc.sv
// tb_wave_display_mc: directed self-checking bench for wave_display_mc
module tb_wave_display_mc;
    localparam logic [23:0] GRN = 24'h00FF00;
    localparam logic [23:0] MAG = 24'hFF00FF;
    localparam logic [23:0] BLK = 24'h000000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [10:0] x = '0;
    logic [9:0] y = '0;
    logic valid = 1'b0;
    logic read_index = 1'b0;
    logic [1:0] ch_en = 2'b11;
    logic freeze = 1'b0;
    logic [15:0] read_value = '0;
    logic [8:0] read_address;
    logic valid_pixel;
    logic [7:0] r, g, b;

    logic [15:0] mem [0:511];
    int vecs = 0;
    int errs = 0;
    logic p_chk = 1'b0;
    logic [24:0] p_exp = '0;
    int p_x = 0;
    int p_y = 0;
    int ramp_rows [6] = '{767, 766, 600, 552, 257, 256};

    wave_display_mc dut (
        .clk(clk),
        .reset(reset),
        .x(x),
        .y(y),
        .valid(valid),
        .read_index(read_index),
        .ch_en(ch_en),
        .freeze(freeze),
        .read_value(read_value),
        .read_address(read_address),
        .valid_pixel(valid_pixel),
        .r(r),
        .g(g),
        .b(b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) read_value <= mem[read_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one pixel per clock; the result of the previous pixel is visible
    // two edges after it was driven, i.e. right after this step's edge.
    task automatic step(input int px, input int py, input logic pv, input logic [23:0] ergb, input logic chk_en);
        logic c;
        logic [24:0] e;
        int qx, qy;
        c = p_chk; e = p_exp; qx = p_x; qy = p_y;
        x = 11'(px); y = 10'(py); valid = pv;
        p_chk = chk_en; p_exp = {ergb != BLK, ergb}; p_x = px; p_y = py;
        @(posedge clk);
        #1;
        if (c) chk($sformatf("pix x=%0d y=%0d", qx, qy), {7'd0, valid_pixel, r, g, b}, {7'd0, e});
    endtask

    task automatic frame();
        step(0, 0, 1'b1, BLK, 1'b1);
    endtask

    // Ramp trace (sample k = k): first column draws rows 766..767, column
    // pair k>=1 draws y = 766-2k .. 769-2k.
    function automatic logic [23:0] ramp_rgb(input int px, input int py);
        int k, lo, hi;
        if (px < 384 || px > 895) return BLK;
        k = (px - 384) / 2;
        lo = (k == 0) ? 766 : 766 - 2 * k;
        hi = (k == 0) ? 767 : 769 - 2 * k;
        return (py >= lo && py <= hi) ? GRN : BLK;
    endfunction

    task automatic row_ramp(input int py);
        for (int px = 380; px < 900; px++) step(px, py, 1'b1, ramp_rgb(px, py), 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0080;
        x = 11'd500;
        y = 10'd300;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {7'd0, valid_pixel, r, g, b}, 32'd0);
        chk("reset read_address", 32'(read_address), 32'h03A);
        reset = 1'b0;

        // ch0 constant 128, ch1 (zero) disabled: only y=510,511 lit
        ch_en = 2'b01;
        frame();
        for (int px = 380; px < 900; px++)
            step(px, 510, 1'b1, (px >= 384 && px <= 895) ? GRN : BLK, 1'b1);
        for (int py = 508; py < 514; py++)
            for (int px = 382; px < 388; px++)
                step(px, py, 1'b1, (px >= 384 && (py == 510 || py == 511)) ? GRN : BLK, 1'b1);
        for (int px = 384; px < 388; px++) step(px, 766, 1'b1, BLK, 1'b1);

        // ch0 ramp
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        for (int j = 0; j < 6; j++) row_ramp(ramp_rows[j]);
        // invalid pixels skip sample 1, so sample 2 joins back to sample 0
        step(384, 766, 1'b1, GRN, 1'b1);
        step(385, 766, 1'b1, GRN, 1'b1);
        step(386, 766, 1'b0, BLK, 1'b1);
        step(387, 766, 1'b0, BLK, 1'b1);
        step(388, 766, 1'b1, GRN, 1'b1);
        step(389, 766, 1'b1, GRN, 1'b1);
        step(390, 766, 1'b1, BLK, 1'b1);

        // asynchronous reset mid-row while the output is lit
        for (int px = 380; px < 602; px++) step(px, 552, 1'b1, ramp_rgb(px, 552), 1'b1);
        #2 reset = 1'b1;
        #1 chk("async reset clears outputs", {7'd0, valid_pixel, r, g, b}, 32'd0);
        p_chk = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        row_ramp(552);
        // reset re-enables ch1 (zero -> rows 766,767); ch0 keeps priority
        for (int px = 384; px < 392; px++) step(px, 766, 1'b1, (px < 388) ? GRN : MAG, 1'b1);

        // both channels constant 64: priority and frame-latched enables
        for (int i = 0; i < 256; i++) mem[i] = 16'h4040;
        ch_en = 2'b11;
        frame();
        for (int px = 382; px < 388; px++) step(px, 638, 1'b1, (px >= 384) ? GRN : BLK, 1'b1);
        step(384, 640, 1'b1, BLK, 1'b1);
        ch_en = 2'b10;
        step(384, 638, 1'b1, GRN, 1'b1);
        step(385, 638, 1'b1, GRN, 1'b1);
        frame();
        step(384, 638, 1'b1, MAG, 1'b1);
        step(385, 638, 1'b1, MAG, 1'b1);
        freeze = 1'b1;
        ch_en = 2'b01;
        frame();
        step(384, 638, 1'b1, MAG, 1'b1);
        step(385, 638, 1'b1, MAG, 1'b1);
        freeze = 1'b0;

        // RAM half selection
        for (int i = 0; i < 256; i++) mem[256 + i] = 16'h8000;
        read_index = 1'b1;
        ch_en = 2'b11;
        step(500, 300, 1'b1, BLK, 1'b1);
        chk("read_address mid-frame", 32'(read_address), 32'h03A);
        frame();
        step(500, 300, 1'b1, BLK, 1'b1);
        chk("read_address after frame", 32'(read_address), 32'h13A);
        for (int px = 384; px < 387; px++) step(px, 510, 1'b1, MAG, 1'b1);
        freeze = 1'b1;
        read_index = 1'b0;
        frame();
        step(500, 300, 1'b1, BLK, 1'b1);
        chk("read_address frozen", 32'(read_address), 32'h13A);
        freeze = 1'b0;
        frame();
        step(500, 300, 1'b1, BLK, 1'b1);
        chk("read_address unfrozen", 32'(read_address), 32'h03A);

        // window edges and invalid pixels
        for (int i = 0; i < 256; i++) mem[i] = 16'h0080;
        step(383, 510, 1'b1, BLK, 1'b1);
        step(384, 510, 1'b1, GRN, 1'b1);
        step(385, 510, 1'b0, BLK, 1'b1);
        step(386, 510, 1'b0, BLK, 1'b1);
        step(388, 510, 1'b1, GRN, 1'b1);
        step(895, 510, 1'b1, GRN, 1'b1);
        step(896, 510, 1'b1, BLK, 1'b1);
        step(400, 255, 1'b1, BLK, 1'b1);
        step(400, 768, 1'b1, BLK, 1'b1);
        step(0, 1, 1'b0, BLK, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
